// File: rtl/hs_cmd_if.sv
// Valid/ready command and response channel
// between a traffic master and a memory-like responder.
interface hs_cmd_if #(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_WD-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd, cmd_addr, cmd_data,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd, cmd_addr, cmd_data,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hs_cmd_master.sv
// Write-then-read traffic generator that checks
// every read response in order against its pattern.
module hs_cmd_master #(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4,
  parameter int MAX_OUT = 4,
  parameter logic [DATA_WD-1:0] SALT = DATA_WD'(4'h5)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [ADDR_WD-1:0] base_addr,
  input  logic [ADDR_WD:0]   len,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_WD:0]   err_cnt,
  hs_cmd_if.master           bus
);
  localparam int CW = ADDR_WD + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_DRAIN, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_WD-1:0] base_q;
  logic [CW-1:0]      len_q;
  logic [CW-1:0]      idx_q;
  logic [CW-1:0]      rsp_idx_q;
  logic [CW-1:0]      out_q;
  logic [CW-1:0]      err_q;
  logic               busy_q, done_q, pass_q;
  logic               cvld_q, cmd_q;
  logic [ADDR_WD-1:0] caddr_q;
  logic [DATA_WD-1:0] cdata_q;

  logic               cmd_fire, rsp_fire, rd_fire;
  logic               last;
  logic [CW-1:0]      idx_nx, out_d, rsp_idx_d;
  logic [ADDR_WD-1:0] nx_addr, rd_addr, chk_addr;

  function automatic logic [DATA_WD-1:0] pat(
    input logic [ADDR_WD-1:0] a
  );
    return DATA_WD'(a) ^ SALT;
  endfunction

  assign cmd_fire  = cvld_q & bus.cmd_ready;
  assign rsp_fire  = bus.rsp_valid & bus.rsp_ready;
  assign rd_fire   = cmd_fire & ~cmd_q;
  assign idx_nx    = idx_q + CW'(1);
  assign last      = (idx_nx == len_q);
  assign out_d     = out_q + CW'(rd_fire) - CW'(rsp_fire);
  assign rsp_idx_d = rsp_idx_q + CW'(rsp_fire);
  assign nx_addr   = base_q + idx_nx[ADDR_WD-1:0];
  assign rd_addr   = cmd_fire ? nx_addr
                   : base_q + idx_q[ADDR_WD-1:0];
  assign chk_addr  = base_q + rsp_idx_q[ADDR_WD-1:0];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (len == '0) ? S_FIN : S_WR;
      S_WR:
        if (cmd_fire && last) state_d = S_RD;
      S_RD:
        if (cmd_fire && last) state_d = S_DRAIN;
      S_DRAIN:
        if (out_d == '0 && rsp_idx_d == len_q)
          state_d = S_FIN;
      S_FIN:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Command generation, response checking, status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rsp_idx_q <= '0;
      out_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cvld_q    <= 1'b0;
      cmd_q     <= 1'b0;
      caddr_q   <= '0;
      cdata_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      out_q     <= out_d;
      rsp_idx_q <= rsp_idx_d;
      if (rsp_fire && bus.rsp_data != pat(chk_addr)
          && err_q != '1)
        err_q <= err_q + CW'(1);
      unique case (state_q)
        S_IDLE:
          if (start) begin
            base_q    <= base_addr;
            len_q     <= len;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            err_q     <= '0;
            idx_q     <= '0;
            rsp_idx_q <= '0;
            if (len != '0) begin
              cvld_q  <= 1'b1;
              cmd_q   <= 1'b1;
              caddr_q <= base_addr;
              cdata_q <= pat(base_addr);
            end
          end
        S_WR:
          if (cmd_fire) begin
            if (last) begin
              idx_q   <= '0;
              cmd_q   <= 1'b0;
              caddr_q <= base_q;
              cdata_q <= '0;
            end else begin
              idx_q   <= idx_nx;
              caddr_q <= nx_addr;
              cdata_q <= pat(nx_addr);
            end
          end
        S_RD:
          if (cmd_fire && last) begin
            idx_q  <= idx_nx;
            cvld_q <= 1'b0;
          end else if (cmd_fire || !cvld_q) begin
            if (cmd_fire) idx_q <= idx_nx;
            cvld_q  <= (out_d < MAX_C);
            caddr_q <= rd_addr;
          end
        S_DRAIN: begin
          cvld_q <= 1'b0;
        end
        S_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (err_q == '0);
        end
        default: begin
          cvld_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign bus.cmd_valid = cvld_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_addr  = caddr_q;
  assign bus.cmd_data  = cdata_q;
  assign bus.rsp_ready = (out_q != '0);
endmodule

// File: tb/tb_hs_cmd_master.sv
// Randomized bench for hs_cmd_master with a
// memory responder and a transaction-level model.
module tb_hs_cmd_master;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, pass;
  logic [AW:0]   err_cnt;

  hs_cmd_if #(.DATA_WD(DW), .ADDR_WD(AW)) bus ();

  hs_cmd_master #(
    .DATA_WD(DW), .ADDR_WD(AW),
    .MAX_OUT(MO), .SALT(4'h5)
  ) dut (
    .clk(clk), .rstn(rstn),
    .start(start), .base_addr(base_addr),
    .len(len), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  logic [DW-1:0] mem [16];
  rsp_t q[$];
  int m_base, m_len, m_corrupt;
  int wr_cnt, rd_cnt, rsp_cnt;
  int rdy_pct, max_dly, done_cnt;
  bit hold, stall;
  logic [9:0] stall_v;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int e_addr(input int i);
    return (m_base + i) % 16;
  endfunction

  function automatic int e_data(input int i);
    return e_addr(i) ^ 5;
  endfunction

  task automatic reset_check();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_cvalid", bus.cmd_valid, 0);
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_addr", bus.cmd_addr, 0);
    chk("rst_data", bus.cmd_data, 0);
    chk("rst_rready", bus.rsp_ready, 0);
  endtask

  task automatic step();
    bit cf, rf;
    int ob;
    logic [DW-1:0] rd;
    bus.cmd_ready = ($urandom_range(99) < rdy_pct);
    if (hold) begin
      bus.rsp_valid = 1'b0;
    end else if (q.size() > 0) begin
      bus.rsp_valid = (q[0].due <= cyc);
      bus.rsp_data  = q[0].d;
    end else begin
      bus.rsp_valid = 1'($urandom_range(1));
      bus.rsp_data  = DW'($urandom);
    end
    ob = rd_cnt - rsp_cnt;
    chk("rsp_ready", bus.rsp_ready, ob != 0);
    chk("max_out", ob <= MO, 1);
    if (stall)
      chk("stable", {bus.cmd_valid, bus.cmd,
                     bus.cmd_addr, bus.cmd_data}, stall_v);
    if (wr_cnt == m_len && rd_cnt == m_len)
      chk("no_cmd", bus.cmd_valid, 0);
    cf = bus.cmd_valid & bus.cmd_ready;
    rf = bus.rsp_valid & bus.rsp_ready;
    stall = bus.cmd_valid & ~bus.cmd_ready;
    stall_v = {bus.cmd_valid, bus.cmd,
               bus.cmd_addr, bus.cmd_data};
    if (cf && bus.cmd) begin
      chk("wr_order", wr_cnt < m_len, 1);
      chk("wr_addr", bus.cmd_addr, e_addr(wr_cnt));
      chk("wr_data", bus.cmd_data, e_data(wr_cnt));
      mem[bus.cmd_addr] = bus.cmd_data;
      wr_cnt++;
    end
    if (cf && !bus.cmd) begin
      chk("rd_order", wr_cnt, m_len);
      chk("rd_addr", bus.cmd_addr, e_addr(rd_cnt));
      chk("rd_data0", bus.cmd_data, 0);
      rd = mem[bus.cmd_addr];
      if (rd_cnt == m_corrupt) rd = rd ^ DW'(1);
      q.push_back('{d: rd,
                    due: cyc + 1 + $urandom_range(max_dly)});
      rd_cnt++;
    end
    if (rf) begin
      chk("rsp_exp", q.size() > 0, 1);
      if (q.size() > 0) void'(q.pop_front());
      rsp_cnt++;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run(input int b, input int l,
                           input int pct, input int dly,
                           input int corrupt);
    chk("pre_busy", busy, 0);
    m_base = b; m_len = l; m_corrupt = corrupt;
    wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0;
    rdy_pct = pct; max_dly = dly; done_cnt = 0;
    start = 1'b1;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    step();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("no_early_done", done, 0);
  endtask

  task automatic run(input int b, input int l,
                     input int pct, input int dly,
                     input int corrupt, input bit poke);
    int cs;
    int ex_err;
    cs = cyc;
    ex_err = (corrupt < l) ? 1 : 0;
    begin_run(b, l, pct, dly, corrupt);
    while (!done && cyc - cs < 3000) begin
      if (poke) begin
        start = 1'($urandom_range(1));
        base_addr = AW'($urandom);
        len = (AW+1)'($urandom);
      end
      step();
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    if (done) begin
      chk("wr_cnt", wr_cnt, l);
      chk("rd_cnt", rd_cnt, l);
      chk("rsp_cnt", rsp_cnt, l);
      chk("busy_at_done", busy, 0);
      chk("err_cnt", err_cnt, ex_err);
      chk("pass", pass, ex_err == 0);
      if (pct == 100 && dly == 0)
        chk("latency", cyc - cs, (l == 0) ? 2 : 2 * l + 3);
    end
    step();
    chk("done_pulse", done, 0);
    chk("pass_hold", pass, ex_err == 0);
    chk("run_count", done_cnt, 1);
  endtask

  initial begin
    int cs;
    rdy_pct = 100; max_dly = 0; m_len = 0; m_base = 0;
    m_corrupt = 99; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0;
    hold = 1'b0; stall = 1'b0; stall_v = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 reset_check();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) step();
    chk("idle_busy", busy, 0);

    run(0, 4, 100, 0, 99, 1'b0);
    run(14, 4, 100, 0, 99, 1'b0);
    run($urandom_range(15), 16, 50, 5, 99, 1'b0);
    run(3, 8, 100, 0, 2, 1'b0);
    run(5, 8, 70, 2, 99, 1'b0);
    run(7, 0, 100, 0, 99, 1'b0);
    run(9, 6, 60, 3, 99, 1'b1);

    hold = 1'b1;
    cs = cyc;
    begin_run(2, 8, 100, 0, 99);
    while (rd_cnt < 3 && cyc - cs < 200) step();
    chk("three_out", rd_cnt - rsp_cnt, 3);
    #1 rstn = 1'b0;
    #1 reset_check();
    q.delete();
    m_len = 0; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0;
    stall = 1'b0; hold = 1'b0; done_cnt = 0;
    repeat (3) step();
    chk("rst_no_done", done_cnt, 0);
    rstn = 1'b1;
    step();
    reset_check();
    run(1, 5, 80, 2, 99, 1'b0);
    run(0, 16, 100, 0, 99, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule

// File: doc/hs_cmd_master.md
Name: hs_cmd_master

Overview:
- Initiator for the valid/ready command/response memory interface: issues a burst of write commands, then the matching read commands, and checks every read response in order.
- Sits on the far end of a handshake command responder (buffered memory/FIFO slave). Used as a traffic generator and self-checker in subsystem benches and as a built-in self-test engine in silicon.

Parameters:
- DATA_WD, 4, command write-data and response-data width.
- ADDR_WD, 4, command address width.
- MAX_OUT, 4, maximum read commands in flight without a response (1..2^ADDR_WD).
- SALT, 4'h5, XOR pattern for generated data (DATA_WD bits).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- base_addr  in  ADDR_WD  first address of the run; captured on accepted start.
- len  in  ADDR_WD+1  number of addresses, 0..2^ADDR_WD; captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  err_cnt==0 at last done; held until next accepted start.
- err_cnt  out  ADDR_WD+1  count of response mismatches, saturating.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  responder accepts command.
- cmd  out  1  1=write, 0=read.
- cmd_addr  out  ADDR_WD  command address.
- cmd_data  out  DATA_WD  write data; don't-care on reads (driven 0).
- rsp_valid  in  1  read response valid.
- rsp_ready  out  1  master accepts response.
- rsp_data  in  DATA_WD  read data.

Behaviour:
- Reset values:
  - busy=0, done=0, pass=0, err_cnt=0.
  - cmd_valid=0, cmd=0, cmd_addr=0, cmd_data=0.
  - rsp_ready=0.
  - FSM=IDLE; all counters 0.
- Reset mid-run aborts immediately with the same values. No partial done is emitted.
- Fire definitions: cmd_fire = cmd_valid & cmd_ready; rsp_fire = rsp_valid & rsp_ready.
- All outputs are registered, except rsp_ready = (outstanding != 0), which is decoded from a register.
- Generated pattern for index i:
  - addr(i) = (base_addr + i) mod 2^ADDR_WD, so the address wraps.
  - data(i) = addr(i)[DATA_WD-1:0] XOR SALT, zero-extended if DATA_WD > ADDR_WD.
- FSM:
  - IDLE: on start, capture base_addr/len, busy<=1, clear err_cnt. If len==0, go to DONE; else go to WR.
  - WR: present write i (cmd=1) with cmd_valid=1.
    - Hold cmd/cmd_addr/cmd_data stable while cmd_valid & !cmd_ready.
    - On cmd_fire, i++. The next command is presented in the following cycle, so back-to-back fires are allowed.
    - After write len-1 fires, reset i=0 and go to RD. No bubble is required.
  - RD: present read i (cmd=0) only while outstanding < MAX_OUT. Otherwise cmd_valid=0.
    - A valid command, once raised, is never withdrawn before it fires.
    - After read len-1 fires, go to DRAIN.
  - DRAIN: cmd_valid=0; wait for outstanding==0 with all len responses received, then go to DONE.
  - DONE: done=1 for one cycle, busy<=0, pass<=(err_cnt==0), then go to IDLE.
- Outstanding counter:
  - +1 on read cmd_fire; -1 on rsp_fire; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT.
- Response checking:
  - Responses are in order. rsp_idx starts at 0.
  - On rsp_fire, compare rsp_data with data(rsp_idx), then rsp_idx++.
  - On mismatch, err_cnt++, saturating at all-ones.
- Boundaries:
  - start while busy is ignored.
  - len = 2^ADDR_WD covers every address exactly once.
  - rsp_valid while outstanding==0 is not accepted (rsp_ready=0) and has no effect.
- Latency: an accepted start gives first cmd_valid in the next cycle.
- Minimum run time with cmd_ready=1 and a 1-cycle responder is 2*len + 3 cycles from start to done.

Test Plan:
- Nominal run: base=0, len=4, cmd_ready=1, responder returns correct data 1 cycle after each read → writes (0,5),(1,4),(2,7),(3,6); then 4 reads; done pulse; pass=1, err_cnt=0.
- Wrap: base=14, len=4 → addresses 14,15,0,1 for both writes and reads; pass=1.
- Backpressure: cmd_ready random 50% and rsp_valid delayed by a random 0-5 cycles, with len=16 → cmd fields stable while stalled; outstanding never exceeds 4; responses checked in order; pass=1.
- Error injection: corrupt response 2 (XOR 1) in a len=8 run → err_cnt=1, pass=0; a following clean run restores pass=1.
- Corner cases:
  - len=0 → no cmd_valid; done one cycle after busy rises.
  - start while busy → ignored; run count is unchanged.
- Reset mid-RD with 3 reads outstanding → all outputs return to reset values; no done; a new start runs normally.
